// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, vends on Select once credit covers PRICE, then pays change one coin per cycle.
// Latency: every output is registered and reflects the inputs sampled on the previous rising edge.
// Backpressure: none; coins arriving while busy, in pairs or overflowing MAXCREDIT are returned via CoinReject.
module vend_controller #(
    parameter int PRICE     = 15,
    parameter int MAXCREDIT = 35,
    parameter int CW        = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          n_i,
    input  logic          d_i,
    input  logic          q_i,
    input  logic          select_i,
    input  logic          cancel_i,
    output logic          vend_o,
    output logic          change_d_o,
    output logic          change_n_o,
    output logic          coin_reject_o,
    output logic [CW-1:0] credit_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW:0]   MAX_C   = (CW+1)'(MAXCREDIT);
    localparam logic [CW-1:0] NICKEL  = CW'(5);
    localparam logic [CW-1:0] DIME    = CW'(10);
    localparam logic [CW-1:0] QUARTER = CW'(25);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          vend_q, vend_d;
    logic          chg_d_q, chg_d_d;
    logic          chg_n_q, chg_n_d;
    logic          reject_q, reject_d;
    logic          busy_q, busy_d;

    logic          coin_any;
    logic          coin_multi;
    logic [CW-1:0] coin_val;
    logic [CW:0]   coin_sum;
    logic [CW-1:0] eff_credit;
    logic [CW-1:0] remain;

    // Decode the coin inputs and the tentative post-coin credit.
    always_comb begin
        coin_any   = n_i | d_i | q_i;
        coin_multi = (n_i & d_i) | (n_i & q_i) | (d_i & q_i);
        coin_val   = '0;
        if (n_i)      coin_val = NICKEL;
        else if (d_i) coin_val = DIME;
        else if (q_i) coin_val = QUARTER;
        coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    end

    // Next-state logic; a change pulse is shown alongside the credit that still includes that coin.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        vend_d     = 1'b0;
        chg_d_d    = 1'b0;
        chg_n_d    = 1'b0;
        reject_d   = 1'b0;
        eff_credit = credit_q;
        remain     = '0;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (coin_any) begin
                    if (coin_multi || (coin_sum > MAX_C)) reject_d = 1'b1;
                    else                                  eff_credit = coin_sum[CW-1:0];
                end
                if (cancel_i && (eff_credit != '0)) begin
                    // Refund includes a coin accepted in the same cycle.
                    state_d  = S_CHANGE;
                    credit_d = eff_credit;
                    chg_d_d  = (eff_credit >= DIME);
                    chg_n_d  = (eff_credit == NICKEL);
                end else if (!coin_any && !cancel_i && select_i && (credit_q >= PRICE_C)) begin
                    state_d  = S_VEND;
                    credit_d = credit_q - PRICE_C;
                    vend_d   = 1'b1;
                end else begin
                    credit_d = eff_credit;
                    state_d  = (eff_credit == '0) ? S_IDLE : S_CREDIT;
                end
            end
            S_VEND: begin
                reject_d = coin_any;
                if (credit_q != '0) begin
                    state_d = S_CHANGE;
                    chg_d_d = (credit_q >= DIME);
                    chg_n_d = (credit_q == NICKEL);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                reject_d = coin_any;
                // Retire the coin being shown this cycle, then queue the next one.
                if (credit_q >= DIME) remain = credit_q - DIME;
                else                  remain = '0;
                credit_d = remain;
                if (remain == '0) begin
                    state_d = S_IDLE;
                end else begin
                    chg_d_d = (remain >= DIME);
                    chg_n_d = (remain == NICKEL);
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    // State and registered outputs; synchronous reset aborts any vend or payout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            vend_q   <= 1'b0;
            chg_d_q  <= 1'b0;
            chg_n_q  <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            vend_q   <= vend_d;
            chg_d_q  <= chg_d_d;
            chg_n_q  <= chg_n_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign vend_o        = vend_q;
    assign change_d_o    = chg_d_q;
    assign change_n_o    = chg_n_q;
    assign coin_reject_o = reject_q;
    assign credit_o      = credit_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: table of per-cycle vectors plus hand-written corner sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Each vector lists the inputs sampled at one edge and the outputs expected after it.
module tb_vend_controller;

    localparam int CW = 6;

    logic          clk;
    logic          rst;
    logic          n, d, q, sel, can;
    logic          vend, chg_d, chg_n, rej, busy;
    logic [CW-1:0] credit;

    int checks   = 0;
    int failures = 0;

    vend_controller #(.PRICE(15), .MAXCREDIT(35), .CW(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .n_i           (n),
        .d_i           (d),
        .q_i           (q),
        .select_i      (sel),
        .cancel_i      (can),
        .vend_o        (vend),
        .change_d_o    (chg_d),
        .change_n_o    (chg_n),
        .coin_reject_o (rej),
        .credit_o      (credit),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, n, d, q, sel, can;
        logic       vend, cd, cn, rej, busy;
        int         credit;
    } vec_t;

    vec_t tbl[34];

    // Apply one cycle of inputs and compare the outputs that follow the edge.
    task automatic step(input string name,
                        input logic i_rst, input logic i_n, input logic i_d, input logic i_q,
                        input logic i_sel, input logic i_can,
                        input logic e_vend, input logic e_cd, input logic e_cn, input logic e_rej,
                        input logic e_busy, input int e_credit);
        logic [10:0] got, exp;
        @(negedge clk);
        rst = i_rst; n = i_n; d = i_d; q = i_q; sel = i_sel; can = i_can;
        @(posedge clk);
        #1;
        got = {vend, chg_d, chg_n, rej, busy, credit};
        exp = {e_vend, e_cd, e_cn, e_rej, e_busy, CW'(e_credit)};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got vend=%b cd=%b cn=%b rej=%b busy=%b credit=%0d, want vend=%b cd=%b cn=%b rej=%b busy=%b credit=%0d",
                     name, vend, chg_d, chg_n, rej, busy, credit,
                     e_vend, e_cd, e_cn, e_rej, e_busy, e_credit);
        end
        checks++;
        if ((32'(vend) + 32'(chg_d) + 32'(chg_n)) > 1) begin
            failures++;
            $display("FAIL %s_excl: vend/cd/cn = %b%b%b, want at most one high", name, vend, chg_d, chg_n);
        end
    endtask

    initial begin
        rst = 1'b1; n = 0; d = 0; q = 0; sel = 0; can = 0;

        //          rst n  d  q  sel can  vend cd cn rej busy credit
        tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0};  // reset
        tbl[1]  = '{0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 10};  // dime
        tbl[2]  = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 15};  // nickel
        tbl[3]  = '{0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1,  0};  // exact-price vend
        tbl[4]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0};  // idle, no change
        tbl[5]  = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 25};  // quarter
        tbl[6]  = '{0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1, 10};  // vend, 10 left
        tbl[7]  = '{0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 10};  // dime change
        tbl[8]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0};  // back to idle
        tbl[9]  = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 25};
        tbl[10] = '{0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 35};  // reach MAXCREDIT
        tbl[11] = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 35};  // overflow nickel rejected
        tbl[12] = '{0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 1, 35};  // cancel: first dime at k+1
        tbl[13] = '{0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 25};
        tbl[14] = '{0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 15};
        tbl[15] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1,  5};  // final nickel
        tbl[16] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0};
        tbl[17] = '{0, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0,  0};  // two coins rejected
        tbl[18] = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  5};
        tbl[19] = '{0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,  5};  // select short of price
        tbl[20] = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 10};
        tbl[21] = '{0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 20};
        tbl[22] = '{0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 1, 20};  // cancel beats select
        tbl[23] = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 1, 1, 10};  // coin during change
        tbl[24] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0};
        tbl[25] = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 25};
        tbl[26] = '{0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 35};
        tbl[27] = '{0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1, 20};
        tbl[28] = '{0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 20};  // first change cycle
        tbl[29] = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0};  // reset mid-change
        tbl[30] = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  5};
        tbl[31] = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 30};
        tbl[32] = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 35};
        tbl[33] = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 35};  // quarter overflow

        for (int i = 0; i < 34; i++) begin
            step($sformatf("vec%0d", i),
                 tbl[i].rst, tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].sel, tbl[i].can,
                 tbl[i].vend, tbl[i].cd, tbl[i].cn, tbl[i].rej, tbl[i].busy, tbl[i].credit);
        end

        // Coin and Cancel together: accepted dime joins the refund.
        step("cc_rst",   1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0);
        step("cc_can0",  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0);   // cancel in IDLE ignored
        step("cc_n",     0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  5);
        step("cc_dcan",  0, 0, 1, 0, 0, 1,  0, 1, 0, 0, 1, 15);
        step("cc_pay2",  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  5);
        step("cc_done",  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0);

        // Coin with Select: coin credited, select ignored; held select then vends.
        step("cs_d",     0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 10);
        step("cs_nsel",  0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 15);
        step("cs_hold",  0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 1,  0);
        step("cs_sel_v", 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0);   // select/cancel ignored in VEND
        step("cs_idle",  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0);

        // Vend leaving a nickel: nickel change then idle; coin in VEND rejected.
        step("vn_q",     0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 25);
        step("vn_n",     0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 30);
        step("vn_sel",   0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 15);
        step("vn_coin",  0, 0, 1, 0, 0, 0,  0, 1, 0, 1, 1, 15);
        step("vn_pay2",  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  5);
        step("vn_done",  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
